// File: rtl/tt_test_sequencer.sv
// tt_test_sequencer: clocked, restartable exhaustive tester for a 3-input
// combinational function. Steps vectors 0..7, waits a settle interval,
// compares z against TRUTH_TABLE and keeps a mismatch count plus the
// first failing vector.
module tt_test_sequencer #(
  parameter logic [7:0] TRUTH_TABLE   = 8'b00111001,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       z,
  output logic       x_0,
  output logic       x_1,
  output logic       x_2,
  output logic [3:0] takt,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       error,
  output logic [3:0] error_count,
  output logic [2:0] first_fail_vec,
  output logic       first_fail_valid
);

  // Last value of the settle counter before moving on to CHECK.
  localparam logic [3:0] SETTLE_LAST =
    (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] settle_cnt;
  logic [2:0] vec;
  logic       mismatch;

  assign vec      = {x_2, x_1, x_0};
  assign mismatch = (z != TRUTH_TABLE[vec]);

  // Sequencer: state, stimulus and all result registers are updated here so
  // every output is registered; abort overrides anything the state would do.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      settle_cnt       <= 4'd0;
      {x_2, x_1, x_0}  <= 3'd0;
      takt             <= 4'd0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      error            <= 1'b0;
      error_count      <= 4'd0;
      first_fail_vec   <= 3'd0;
      first_fail_valid <= 1'b0;
    end else begin
      error <= 1'b0;
      if (abort) begin
        state           <= IDLE;
        {x_2, x_1, x_0} <= 3'd0;
        takt            <= 4'd0;
        busy            <= 1'b0;
        done            <= 1'b0;
        pass            <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state            <= APPLY;
              takt             <= 4'd0;
              error_count      <= 4'd0;
              first_fail_valid <= 1'b0;
              first_fail_vec   <= 3'd0;
              busy             <= 1'b1;
              done             <= 1'b0;
              pass             <= 1'b0;
            end
          end
          APPLY: begin
            {x_2, x_1, x_0} <= takt[2:0];
            settle_cnt      <= 4'd0;
            state           <= (SETTLE_CYCLES > 0) ? SETTLE : CHECK;
          end
          SETTLE: begin
            settle_cnt <= settle_cnt + 4'd1;
            if (settle_cnt == SETTLE_LAST) begin
              state <= CHECK;
            end
          end
          CHECK: begin
            if (mismatch) begin
              error       <= 1'b1;
              error_count <= error_count + 4'd1;
              if (!first_fail_valid) begin
                first_fail_vec   <= vec;
                first_fail_valid <= 1'b1;
              end
            end
            if (takt == 4'd7) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (error_count == 4'd0) && !mismatch;
            end else begin
              takt  <= takt + 4'd1;
              state <= APPLY;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
